// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : MDUOp encodings, FSM states, default latencies and op helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   localparam int DEFAULT_MULT_CYCLES = 5;
   localparam int DEFAULT_DIV_CYCLES  = 10;

   function automatic logic is_mult(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_calc.sv
// ============================================================================
// mdu_calc : combinational multiply/divide of latched operands into HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_calc
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi_next,
   output logic [31:0] lo_next,
   output logic        hold
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] b_safe;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic [31:0] q_s;
   logic [31:0] r_s;

   always_comb begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};
      // Divisor forced non-zero so the datapath never sees x/0; result is discarded via hold
      b_safe = (b == 32'd0) ? 32'd1 : b;
      a_abs  = a[31] ? (32'd0 - a) : a;
      b_abs  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
      // 0x80000000 / -1 lands on 0x80000000 rem 0 through the magnitude path
      q_s    = a_abs / b_abs;
      r_s    = a_abs % b_abs;

      hi_next = 32'd0;
      lo_next = 32'd0;
      hold    = 1'b0;
      case (op)
         MDU_MULT:  {hi_next, lo_next} = prod_s;
         MDU_MULTU: {hi_next, lo_next} = prod_u;
         MDU_DIV: begin
            lo_next = (a[31] ^ b_safe[31]) ? (32'd0 - q_s) : q_s;
            hi_next = a[31] ? (32'd0 - r_s) : r_s;
            hold    = (b == 32'd0);
         end
         MDU_DIVU: begin
            lo_next = a / b_safe;
            hi_next = a % b_safe;
            hold    = (b == 32'd0);
         end
         default: begin
            hi_next = 32'd0;
            lo_next = 32'd0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// ============================================================================
// mdu : multi-cycle multiply/divide unit with HI/LO register pair
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   mdu_state_e  state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi_q, lo_q;
   logic [31:0] hi_next, lo_next;
   logic        hold;
   logic        launch, commit;

   mdu_calc u_calc (
      .op      (op_q),
      .a       (a_q),
      .b       (b_q),
      .hi_next (hi_next),
      .lo_next (lo_next),
      .hold    (hold)
   );

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      launch     = 1'b0;
      commit     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && (is_mult(MDUOp) || is_div(MDUOp))) begin
               launch     = 1'b1;
               state_next = ST_RUN;
               cnt_next   = is_mult(MDUOp) ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
            end
         end
         ST_RUN: begin
            if (cnt == 4'd0) begin
               commit     = 1'b1;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
         op_q  <= MDU_NONE;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (launch) begin
            op_q <= MDUOp;
            a_q  <= A;
            b_q  <= B;
         end
         if (commit && !hold) begin
            hi_q <= hi_next;
            lo_q <= lo_next;
         end
         // Moves only take effect while idle; commit never coincides with IDLE
         if (state == ST_IDLE && MDUOp == MDU_MTHI) hi_q <= A;
         if (state == ST_IDLE && MDUOp == MDU_MTLO) lo_q <= A;
      end
   end

   assign busy = (state == ST_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

`default_nettype wire
